// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared constants and capture-FSM state type for the PWM blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int PWM_CNT_W       = 16;
    localparam int PWM_SYNC_STAGES = 2;
    localparam int PWM_TIMEOUT     = 4800;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        MEASURE = 2'd2,
        STUCK   = 2'd3
    } capture_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sync.sv
// ============================================================================
// Module  : pwm_sync
// Brief   : Resettable multi-stage synchronizer with rising-edge detect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic s,
    output logic rise
);

    logic [STAGES-1:0] r_chain;
    logic              r_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_s_d   <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], async_in};
            r_s_d   <= r_chain[STAGES-1];
        end
    end

    assign s    = r_chain[STAGES-1];
    assign rise = r_chain[STAGES-1] & ~r_s_d;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module  : pwm_capture
// Brief   : Measures high time and period of an incoming PWM line, flags stuck.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic             sample_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_sync_fill  = CNT_W'(SYNC_STAGES);

    logic w_s;
    logic w_rise;

    capture_state_t   r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
    logic [CNT_W-1:0] r_high, w_high_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_stuck, w_stuck_nxt;
    logic             r_level, w_level_nxt;
    logic             w_enter_stuck;

    pwm_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pwm_in),
        .s        (w_s),
        .rise     (w_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARM;
            r_cnt    <= '0;
            r_hcnt   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_high   <= w_high_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_stuck  <= w_stuck_nxt;
            r_level  <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hcnt_nxt    = r_hcnt;
        w_high_nxt    = r_high;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_stuck_nxt   = r_stuck;
        w_level_nxt   = r_level;
        w_enter_stuck = 1'b0;

        case (r_state)
            // Leave ARM only once the chain has flushed since reset, so a line
            // that is already high never produces a false first edge.
            ARM: begin
                w_cnt_nxt = r_cnt + c_one;
                if (r_cnt == c_timeout_m1) begin
                    w_enter_stuck = 1'b1;
                end else if (!w_s && (r_cnt >= c_sync_fill)) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_cnt_nxt   = c_one;
                    w_hcnt_nxt  = c_one;
                    w_state_nxt = MEASURE;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                    if (r_cnt == c_timeout_m1) begin
                        w_enter_stuck = 1'b1;
                    end
                end
            end
            // cnt equals cycles since the last rise, so a period of exactly
            // TIMEOUT still measures and only a longer one times out.
            MEASURE: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_high_nxt   = r_hcnt;
                    w_valid_nxt  = 1'b1;
                    w_stuck_nxt  = 1'b0;
                    w_cnt_nxt    = c_one;
                    w_hcnt_nxt   = c_one;
                end else if (r_cnt == c_timeout) begin
                    w_enter_stuck = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + c_one;
                    w_hcnt_nxt = r_hcnt + {{(CNT_W-1){1'b0}}, w_s};
                end
            end
            STUCK: begin
                if (w_rise) begin
                    w_cnt_nxt   = c_one;
                    w_hcnt_nxt  = c_one;
                    w_state_nxt = MEASURE;
                end
            end
            default: begin
                w_state_nxt = ARM;
            end
        endcase

        if (w_enter_stuck) begin
            w_state_nxt  = STUCK;
            w_stuck_nxt  = 1'b1;
            w_level_nxt  = w_s;
            w_high_nxt   = '0;
            w_period_nxt = '0;
            w_valid_nxt  = 1'b1;
        end
    end

    assign high_cycles   = r_high;
    assign period_cycles = r_period;
    assign sample_valid  = r_valid;
    assign stuck         = r_stuck;
    assign stuck_level   = r_level;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module  : tb_pwm_capture
// Brief   : Self-checking bench for pwm_capture against an event-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 4800;
    localparam int MAXE    = 1 << 17;

    typedef struct {
        int at;
        int high;
        int period;
        int stk;
        int lvl;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] period_cycles;
    logic             sample_valid;
    logic             stuck;
    logic             stuck_level;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  phase_r = 0;
    bit  hist [0:MAXE-1];
    ev_t obs_q[$];
    ev_t exp_q[$];

    pwm_capture #(
        .CNT_W         (CNT_W),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pwm_in        (pwm_in),
        .high_cycles   (high_cycles),
        .period_cycles (period_cycles),
        .sample_valid  (sample_valid),
        .stuck         (stuck),
        .stuck_level   (stuck_level)
    );

    always #5 clk = ~clk;

    // Edge n is the n-th posedge; hist[n] is the line level sampled there.
    always @(posedge clk) begin
        cyc = cyc + 1;
        hist[cyc] = pwm_in;
    end

    always @(negedge clk) begin
        if (!rst && sample_valid)
            obs_q.push_back('{cyc, int'(high_cycles), int'(period_cycles),
                              int'(stuck), int'(stuck_level)});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Synchronized level the capture logic acts on at edge e.
    function automatic bit sv(input int e);
        if (e - SYNC < phase_r + 1) return 1'b0;
        return hist[e - SYNC];
    endfunction

    function automatic int count_high(input int from, input int upto);
        int n = 0;
        for (int k = from; k < upto; k++) n += int'(sv(k));
        return n;
    endfunction

    // Expected strobes from reset edge phase_r through edge z, derived from
    // the rise times of the synchronized line and the timeout deadlines.
    task automatic build_exp(input int z);
        int deadline;
        int start;
        int last;
        bit waiting;
        bit lvl;
        bit r;
        exp_q.delete();
        deadline = phase_r + TIMEOUT;
        start    = -1;
        last     = -1;
        waiting  = 1'b0;
        lvl      = 1'b0;
        for (int k = phase_r + 1 + SYNC; k < deadline && k <= z && start < 0; k++)
            if (!sv(k)) start = k + 1;
        if (start < 0) begin
            if (deadline > z) return;
            lvl = sv(deadline);
            exp_q.push_back('{deadline, 0, 0, 1, int'(lvl)});
            waiting = 1'b1;
            start   = deadline + 1;
        end
        for (int e = start; e <= z; e++) begin
            r = sv(e) && !sv(e - 1);
            if (r) begin
                if (last >= 0 && !waiting)
                    exp_q.push_back('{e, count_high(last, e), e - last, 0, int'(lvl)});
                last     = e;
                waiting  = 1'b0;
                deadline = e + TIMEOUT;
            end else if (!waiting && e == deadline) begin
                lvl = sv(e);
                exp_q.push_back('{e, 0, 0, 1, int'(lvl)});
                waiting = 1'b1;
            end
        end
    endtask

    task automatic compare_phase(input string tag);
        int n;
        build_exp(cyc);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_at"},     obs_q[i].at,     exp_q[i].at);
            chk({tag, "_high"},   obs_q[i].high,   exp_q[i].high);
            chk({tag, "_period"}, obs_q[i].period, exp_q[i].period);
            chk({tag, "_stuck"},  obs_q[i].stk,    exp_q[i].stk);
            chk({tag, "_level"},  obs_q[i].lvl,    exp_q[i].lvl);
            chk({tag, "_h_le_p"}, int'(obs_q[i].high <= obs_q[i].period), 1);
        end
        obs_q.delete();
    endtask

    task automatic do_reset(input int n, input logic lvl);
        rst    = 1'b1;
        pwm_in = lvl;
        repeat (n) @(negedge clk);
        phase_r = cyc;
        chk("rst_high",   int'(high_cycles),   0);
        chk("rst_period", int'(period_cycles), 0);
        chk("rst_valid",  int'(sample_valid),  0);
        chk("rst_stuck",  int'(stuck),         0);
        chk("rst_level",  int'(stuck_level),   0);
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic hold(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int h, input int l, input int reps);
        repeat (reps) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    initial begin
        int h;
        int l;

        do_reset(3, 1'b0);
        wave(3, 7, 8);
        hold(1'b0, 4);
        chk("p1_high",   int'(high_cycles),   3);
        chk("p1_period", int'(period_cycles), 10);
        chk("p1_stuck",  int'(stuck),         0);
        compare_phase("p1");

        do_reset(2, 1'b1);
        hold(1'b1, TIMEOUT + 50);
        chk("p2_stuck", int'(stuck),         1);
        chk("p2_level", int'(stuck_level),   1);
        chk("p2_high",  int'(high_cycles),   0);
        compare_phase("p2");

        do_reset(2, 1'b0);
        hold(1'b0, 5000);
        chk("p3_stuck", int'(stuck),       1);
        chk("p3_level", int'(stuck_level), 0);
        wave(5, 5, 3);
        hold(1'b0, 4);
        chk("p3_high",   int'(high_cycles),   5);
        chk("p3_period", int'(period_cycles), 10);
        compare_phase("p3");

        do_reset(2, 1'b0);
        wave(1, 19, 5);
        chk("p4_high",   int'(high_cycles),   1);
        chk("p4_period", int'(period_cycles), 20);
        compare_phase("p4");

        do_reset(2, 1'b0);
        wave(4, 8, 3);
        hold(1'b1, 2);
        compare_phase("p5a");
        do_reset(1, 1'b1);
        hold(1'b1, 2);
        hold(1'b0, 8);
        wave(4, 8, 4);
        hold(1'b0, 4);
        chk("p5_high",   int'(high_cycles),   4);
        chk("p5_period", int'(period_cycles), 12);
        compare_phase("p5b");

        do_reset(2, 1'b0);
        hold(1'b0, 10);
        wave(1, TIMEOUT - 1, 2);
        chk("p6_period", int'(period_cycles), TIMEOUT);
        wave(1, TIMEOUT, 1);
        wave(1, 9, 2);
        hold(1'b0, 4);
        compare_phase("p6");

        do_reset(2, 1'b0);
        for (int i = 0; i < 30; i++) begin
            h = $urandom_range(1, 20);
            l = (i == 12) ? TIMEOUT + $urandom_range(1, 40) : $urandom_range(1, 20);
            wave(h, l, 1);
        end
        hold(1'b0, 4);
        compare_phase("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
